// File: rtl/pc_ctrl_pkg.sv
// Shared jump-class codes, exception vector, reset PC and fetch-sequencer
// state encodings used by pc_ctrl, pc_redirect_buf and the npc block.
package pc_ctrl_pkg;

  localparam logic [3:0] NPC_NEXT  = 4'd0;
  localparam logic [3:0] NPC_EQUAL = 4'd1;
  localparam logic [3:0] NPC_NEQ   = 4'd2;
  localparam logic [3:0] NPC_BLEZ  = 4'd3;
  localparam logic [3:0] NPC_BGTZ  = 4'd4;
  localparam logic [3:0] NPC_BLTZ  = 4'd5;
  localparam logic [3:0] NPC_BGEZ  = 4'd6;
  localparam logic [3:0] NPC_J     = 4'd7;
  localparam logic [3:0] NPC_JAL   = 4'd8;
  localparam logic [3:0] NPC_REG   = 4'd9;
  localparam logic [3:0] NPC_ISR   = 4'd14;
  localparam logic [3:0] NPC_EPC   = 4'd15;

  localparam logic [31:0] NPC_ISR_ADDRESS = 32'h0000_4180;
  localparam logic [31:0] PCC_RESET_PC    = 32'h0000_3000;

  typedef enum logic [1:0] {
    PCC_BOOT  = 2'd0,
    PCC_FETCH = 2'd1,
    PCC_ADEL  = 2'd2
  } pcc_state_e;

  // Any decoded jump class other than sequential / redirect makes the next fetch a delay slot.
  function automatic logic is_branch(input logic [3:0] mode);
    return !(mode == NPC_NEXT || mode == NPC_ISR || mode == NPC_EPC);
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds exception/ERET redirects that arrive while a fetch is outstanding.
// Latency: selects are combinational from pending flags and live requests.
// Backpressure: flags persist until apply; exc always beats eret.
module pc_redirect_buf
  import pc_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic exc_req,
  input  logic eret,
  input  logic apply,
  output logic pend_exc,
  output logic pend_eret,
  output logic sel_isr,
  output logic sel_epc
);

  assign sel_isr = pend_exc | exc_req;
  assign sel_epc = !sel_isr && (pend_eret | eret);

  // On apply any same-cycle request is consumed directly, so both flags clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_exc  <= 1'b0;
      pend_eret <= 1'b0;
    end else if (apply) begin
      pend_exc  <= 1'b0;
      pend_eret <= 1'b0;
    end else if (exc_req) begin
      pend_exc  <= 1'b1;
      pend_eret <= 1'b0;
    end else if (eret && !pend_exc) begin
      pend_eret <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch sequencer: owns the PC, drives npc, runs the IM req/ack handshake.
// Latency: one PC step per acked, unstalled fetch; redirects apply on next ack.
// Backpressure: stall holds pc with im_req high unless a redirect is pending.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PCC_RESET_PC,
  parameter logic [31:0] ISR_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        id_valid,
  input  logic [3:0]  id_jump_mode,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] npc_next,
  output logic [3:0]  npc_mode,
  output logic [31:0] npc_pc,
  output logic [31:0] pc,
  output logic        im_req,
  input  logic        im_ack,
  output logic        fetch_valid,
  output logic        if_bd,
  output logic        exc_ack,
  output logic        if_adel
);

  pcc_state_e state, state_nxt;
  logic in_adel, eret_m, done, advance, adel_exit, apply;
  logic pend_exc, pend_eret, sel_isr, sel_epc;

  assign in_adel   = (state == PCC_ADEL);
  assign eret_m    = eret & ~in_adel;
  assign done      = (state == PCC_FETCH) && im_ack;
  assign advance   = done && (!stall || pend_exc || pend_eret);
  assign adel_exit = in_adel && exc_req;
  assign apply     = advance | adel_exit;

  pc_redirect_buf u_redirect_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .exc_req   (exc_req),
    .eret      (eret_m),
    .apply     (apply),
    .pend_exc  (pend_exc),
    .pend_eret (pend_eret),
    .sel_isr   (sel_isr),
    .sel_epc   (sel_epc)
  );

  always_comb begin
    npc_mode = NPC_NEXT;
    if (sel_isr)       npc_mode = NPC_ISR;
    else if (sel_epc)  npc_mode = NPC_EPC;
    else if (id_valid) npc_mode = id_jump_mode;
  end

  // The instruction fetched alongside a redirect is flushed rather than accepted.
  assign fetch_valid = advance && !(sel_isr || sel_epc);
  assign if_bd       = fetch_valid && id_valid && is_branch(id_jump_mode);

  always_comb begin
    state_nxt = state;
    case (state)
      PCC_BOOT:  state_nxt = PCC_FETCH;
      PCC_FETCH: if (advance && (npc_next[1:0] != 2'b00)) state_nxt = PCC_ADEL;
      PCC_ADEL:  if (exc_req) state_nxt = PCC_FETCH;
      default:   state_nxt = PCC_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PCC_BOOT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      exc_ack <= 1'b0;
    end else begin
      exc_ack <= apply && sel_isr;
      if (adel_exit)    pc <= ISR_PC;
      else if (advance) pc <= npc_next;
    end
  end

  // Decoded from registered state so reset drops the request asynchronously.
  assign im_req  = (state == PCC_FETCH);
  assign if_adel = (pc[1:0] != 2'b00);
  assign npc_pc  = pc;

  a_isr_vector : assert property (@(posedge clk) disable iff (!rst_n) ISR_PC == NPC_ISR_ADDRESS)
    else $error("pc_ctrl: ISR_PC differs from NPC_ISR_ADDRESS");

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed vector bench for pc_ctrl: inputs driven just after posedge,
// all outputs compared at the following negedge.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  logic        clk, rst_n, stall, id_valid, exc_req, eret, im_ack;
  logic [3:0]  id_jump_mode, npc_mode;
  logic [31:0] npc_next, npc_pc, pc;
  logic        im_req, fetch_valid, if_bd, exc_ack, if_adel;

  pc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_valid(id_valid),
    .id_jump_mode(id_jump_mode), .exc_req(exc_req), .eret(eret),
    .npc_next(npc_next), .npc_mode(npc_mode), .npc_pc(npc_pc), .pc(pc),
    .im_req(im_req), .im_ack(im_ack), .fetch_valid(fetch_valid),
    .if_bd(if_bd), .exc_ack(exc_ack), .if_adel(if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, idv;
    logic [3:0]  jm;
    logic        ex, er, ak;
    logic [31:0] nn;
    logic [31:0] e_pc;
    logic        e_req, e_fv, e_bd;
    logic [3:0]  e_mode;
    logic        e_ack, e_adel;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic add(input logic st, input logic idv, input logic [3:0] jm,
                     input logic ex, input logic er, input logic ak, input logic [31:0] nn,
                     input logic [31:0] e_pc, input logic e_req, input logic e_fv,
                     input logic e_bd, input logic [3:0] e_mode, input logic e_ack,
                     input logic e_adel);
    vec_t v;
    v.st = st; v.idv = idv; v.jm = jm; v.ex = ex; v.er = er; v.ak = ak; v.nn = nn;
    v.e_pc = e_pc; v.e_req = e_req; v.e_fv = e_fv; v.e_bd = e_bd;
    v.e_mode = e_mode; v.e_ack = e_ack; v.e_adel = e_adel;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; id_valid = 1'b0; id_jump_mode = NPC_NEXT;
    exc_req = 1'b0; eret = 1'b0; im_ack = 1'b1; npc_next = 32'h0;

    //  st idv jm         ex er ak npc_next        pc             req fv bd mode       eack adel
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_3004, 32'h0000_3000, 0, 0, 0, NPC_NEXT,  0, 0); // boot
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_3004, 32'h0000_3000, 1, 1, 0, NPC_NEXT,  0, 0);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_3008, 32'h0000_3004, 1, 1, 0, NPC_NEXT,  0, 0);
    add(1, 0, NPC_NEXT,  0, 0, 1, 32'h0000_300C, 32'h0000_3008, 1, 0, 0, NPC_NEXT,  0, 0); // stall x3
    add(1, 0, NPC_NEXT,  0, 0, 1, 32'h0000_300C, 32'h0000_3008, 1, 0, 0, NPC_NEXT,  0, 0);
    add(1, 0, NPC_NEXT,  0, 0, 1, 32'h0000_300C, 32'h0000_3008, 1, 0, 0, NPC_NEXT,  0, 0);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_300C, 32'h0000_3008, 1, 1, 0, NPC_NEXT,  0, 0);
    add(0, 1, NPC_EQUAL, 0, 0, 1, 32'h0000_3040, 32'h0000_300C, 1, 1, 1, NPC_EQUAL, 0, 0); // taken branch
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_3044, 32'h0000_3040, 1, 1, 0, NPC_NEXT,  0, 0);
    add(0, 0, NPC_NEXT,  1, 0, 0, 32'h0000_4180, 32'h0000_3044, 1, 0, 0, NPC_ISR,   0, 0); // exc pulse, no ack
    add(0, 0, NPC_NEXT,  0, 0, 0, 32'h0000_4180, 32'h0000_3044, 1, 0, 0, NPC_ISR,   0, 0);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4180, 32'h0000_3044, 1, 0, 0, NPC_ISR,   0, 0);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4184, 32'h0000_4180, 1, 1, 0, NPC_NEXT,  1, 0);
    add(1, 0, NPC_NEXT,  1, 1, 1, 32'h0000_4180, 32'h0000_4184, 1, 0, 0, NPC_ISR,   0, 0); // exc+eret under stall
    add(1, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4180, 32'h0000_4184, 1, 0, 0, NPC_ISR,   0, 0);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4184, 32'h0000_4180, 1, 1, 0, NPC_NEXT,  1, 0);
    add(0, 1, NPC_REG,   0, 0, 1, 32'h0000_3002, 32'h0000_4184, 1, 1, 1, NPC_REG,   0, 0); // misaligned jr
    add(0, 0, NPC_NEXT,  0, 1, 1, 32'h0000_4180, 32'h0000_3002, 0, 0, 0, NPC_NEXT,  0, 1);
    add(1, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4180, 32'h0000_3002, 0, 0, 0, NPC_NEXT,  0, 1);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4180, 32'h0000_3002, 0, 0, 0, NPC_NEXT,  0, 1);
    add(0, 0, NPC_NEXT,  0, 0, 0, 32'h0000_4180, 32'h0000_3002, 0, 0, 0, NPC_NEXT,  0, 1);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4180, 32'h0000_3002, 0, 0, 0, NPC_NEXT,  0, 1);
    add(0, 0, NPC_NEXT,  1, 0, 1, 32'h0000_4180, 32'h0000_3002, 0, 0, 0, NPC_ISR,   0, 1); // leave ADEL
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4184, 32'h0000_4180, 1, 1, 0, NPC_NEXT,  1, 0);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4188, 32'h0000_4184, 1, 1, 0, NPC_NEXT,  0, 0);
    add(0, 0, NPC_NEXT,  0, 1, 1, 32'h0000_3010, 32'h0000_4188, 1, 0, 0, NPC_EPC,   0, 0); // eret direct
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_3014, 32'h0000_3010, 1, 1, 0, NPC_NEXT,  0, 0);
    add(0, 1, NPC_J,     0, 0, 1, 32'hFFFF_FFFC, 32'h0000_3014, 1, 1, 1, NPC_J,     0, 0);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_0000, 32'hFFFF_FFFC, 1, 1, 0, NPC_NEXT,  0, 0); // wrap
    add(0, 0, NPC_NEXT,  0, 1, 0, 32'h0000_4180, 32'h0000_0000, 1, 0, 0, NPC_EPC,   0, 0); // eret pending
    add(0, 0, NPC_NEXT,  1, 0, 0, 32'h0000_4180, 32'h0000_0000, 1, 0, 0, NPC_ISR,   0, 0); // exc clears it
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4180, 32'h0000_0000, 1, 0, 0, NPC_ISR,   0, 0);
    add(0, 0, NPC_NEXT,  0, 0, 1, 32'h0000_4184, 32'h0000_4180, 1, 1, 0, NPC_NEXT,  1, 0);

    @(negedge clk);
    chk("rst_pc", -1, pc, 32'h0000_3000);
    chk("rst_im_req", -1, {31'b0, im_req}, 32'h0);
    chk("rst_fetch_valid", -1, {31'b0, fetch_valid}, 32'h0);
    chk("rst_exc_ack", -1, {31'b0, exc_ack}, 32'h0);
    chk("rst_if_adel", -1, {31'b0, if_adel}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].st; id_valid = vecs[i].idv; id_jump_mode = vecs[i].jm;
      exc_req = vecs[i].ex; eret = vecs[i].er; im_ack = vecs[i].ak; npc_next = vecs[i].nn;
      @(negedge clk);
      chk("pc", i, pc, vecs[i].e_pc);
      chk("npc_pc", i, npc_pc, vecs[i].e_pc);
      chk("im_req", i, {31'b0, im_req}, {31'b0, vecs[i].e_req});
      chk("fetch_valid", i, {31'b0, fetch_valid}, {31'b0, vecs[i].e_fv});
      chk("if_bd", i, {31'b0, if_bd}, {31'b0, vecs[i].e_bd});
      chk("npc_mode", i, {28'b0, npc_mode}, {28'b0, vecs[i].e_mode});
      chk("exc_ack", i, {31'b0, exc_ack}, {31'b0, vecs[i].e_ack});
      chk("if_adel", i, {31'b0, if_adel}, {31'b0, vecs[i].e_adel});
      @(posedge clk); #1;
    end

    // Reset asserted mid-cycle with a fetch outstanding must drop im_req at once.
    stall = 1'b0; id_valid = 1'b0; exc_req = 1'b0; eret = 1'b0; im_ack = 1'b0;
    #2;
    chk("pre_arst_im_req", 100, {31'b0, im_req}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_im_req", 101, {31'b0, im_req}, 32'h0);
    chk("arst_pc", 101, pc, 32'h0000_3000);
    @(posedge clk); #1;
    rst_n = 1'b1; im_ack = 1'b1;
    @(negedge clk);
    chk("reboot_im_req", 102, {31'b0, im_req}, 32'h0);
    @(negedge clk);
    chk("refetch_im_req", 103, {31'b0, im_req}, 32'h1);
    chk("refetch_pc", 103, pc, 32'h0000_3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Fetch-stage sequencer that owns the architectural PC register and drives the npc block: it selects npc's jump_mode and feeds it curr_pc.
- Runs a request/acknowledge fetch handshake with IM, holds the PC under hazard stall, and buffers exception/ERET redirects that arrive mid-fetch.
- Tracks branch-delay-slot status for CP0 and flags misaligned fetch addresses.
- Sits between the hazard unit, the ID-stage decoder, CP0, npc and IM.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ISR_PC, 32'h0000_4180, exception vector; must equal NPC_ISR_ADDRESS (checked by assertion).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard-unit hold request.
- id_valid  in  1  ID stage holds a real instruction.
- id_jump_mode  in  4  NPC_* jump class decoded for the ID instruction.
- exc_req  in  1  CP0 exception/interrupt request (may be a 1-cycle pulse).
- eret  in  1  ERET present in ID (may be a 1-cycle pulse).
- npc_next  in  32  next_pc returned by npc.
- npc_mode  out  4  jump_mode driven to npc.
- npc_pc  out  32  curr_pc driven to npc; always equals pc.
- pc  out  32  current fetch address to IM.
- im_req  out  1  fetch request.
- im_ack  in  1  IM returns the instruction at pc this cycle.
- fetch_valid  out  1  fetched instruction is accepted into ID this cycle.
- if_bd  out  1  the accepted instruction is a delay slot.
- exc_ack  out  1  1-cycle pulse: ISR redirect applied.
- if_adel  out  1  pc is misaligned (pc[1:0] != 0).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - im_req, fetch_valid, if_bd, exc_ack = 0; both pending flags cleared.
  - Any outstanding fetch is abandoned; im_req drops immediately, not at a clock edge.
- States:
  - BOOT: im_req=0 for one cycle, then FETCH.
  - FETCH: im_req=1 and held until im_ack.
  - ADEL: im_req=0, if_adel=1.
- done = state==FETCH && im_ack.
- advance = done && (!stall || pend_exc || pend_eret). A pending redirect overrides stall.
- Pending latch:
  - exc_req sets pend_exc; eret sets pend_eret.
  - Requests arriving on the apply cycle are applied directly, not latched.
  - exc_req and eret in the same cycle: exc wins, eret is discarded.
  - Exception while ERET is pending: pend_eret is cleared.
- npc_mode priority (combinational):
  1. (pend_exc || exc_req) gives NPC_ISR.
  2. (pend_eret || eret) gives NPC_EPC.
  3. id_valid gives id_jump_mode.
  4. Otherwise NPC_NEXT.
- On advance:
  - pc <= npc_next.
  - Pending flags for the applied redirect are cleared.
  - exc_ack=1 next cycle if ISR was applied.
- PC sequencing:
  - Sequential step wraps naturally: 32'hFFFF_FFFC goes to 32'h0000_0000.
  - Branch decision is taken from the ID inputs on the advance cycle. ID is stable while not advancing, so no capture register is needed.
- Fetch outputs:
  - fetch_valid = advance && no redirect applied. The instruction fetched before an ISR/EPC redirect is flushed.
  - if_bd = fetch_valid && id_valid && id_jump_mode is branch-class (any code except NPC_NEXT, NPC_ISR, NPC_EPC).
- Stall without redirect: pc holds, fetch_valid=0, im_req stays 1. The ack is re-taken on a later cycle, since IM is combinational and ack repeats.
- Misaligned target:
  - If a new pc has pc[1:0] != 0, go to ADEL; stay there with no request.
  - Leave ADEL only on exc_req: pc<=ISR_PC, exc_ack pulse, then FETCH. All other inputs are ignored in ADEL.
- Outputs are registered except npc_mode, fetch_valid and if_bd.

Decomposition:
- npc.h (shared):
  - All NPC_* codes, including NPC_NEXT = 4'd0.
  - NPC_ISR_ADDRESS.
  - PCC_BOOT/PCC_FETCH/PCC_ADEL state encodings (2-bit).
  - PCC_RESET_PC default.
- One sub-module, pc_redirect_buf: holds pend_exc/pend_eret and implements the priority/clear rules.
- The state machine and PC register stay in pc_ctrl.

Test Plan:
- Release rst_n, im_ack=1 always -> cycle 0 BOOT with im_req=0; then pc=0x3000, 0x3004, 0x3008 with fetch_valid=1 each cycle.
- Taken branch: id_jump_mode=NPC_EQUAL, id_valid=1, npc_next=0x3040 on advance -> pc=0x3040; the accepted delay slot has if_bd=1.
- stall=1 for 3 cycles with im_ack=1 -> pc stays 0x3008, fetch_valid=0, im_req=1; resumes 0x300C after stall drops.
- exc_req 1-cycle pulse while im_ack=0 for 2 cycles -> npc_mode=NPC_ISR held; on ack pc=0x4180, fetch_valid=0, exc_ack pulses once.
- exc_req and eret asserted in the same cycle with stall=1 -> pc=0x4180, EPC never applied, pend_eret=0.
- NPC_REG with npc_next=0x3002 -> state ADEL, if_adel=1, im_req=0 for 5 cycles; exc_req -> pc=0x4180, FETCH resumes.
